// File: rtl/rr_demux_sched_if.sv
// rtl/rr_demux_sched_if.sv - request/grant bundle between requesters and the round-robin demux scheduler
interface rr_demux_sched_if #(
  parameter int BURST_W = 4
);
  logic [7:0]         req;
  logic [BURST_W-1:0] burst_len;
  logic [2:0]         sel;
  logic               in;
  logic               busy;
  logic               grant_done;

  modport master (
    output req, burst_len,
    input  sel, in, busy, grant_done
  );

  modport slave (
    input  req, burst_len,
    output sel, in, busy, grant_done
  );
endinterface

// File: rtl/rr_demux_sched.sv
// rtl/rr_demux_sched.sv - round-robin scheduler driving the select and data input of a 1-to-8 demux
module rr_demux_sched #(
  parameter int BURST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  rr_demux_sched_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         sel_q, sel_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               in_q, in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               found;
  logic [2:0]         winner;
  logic [2:0]         idx;

  // Search starts just above the last served channel so it ends up with lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      GRANT: begin
        if (cnt_q == BURST_W'(1) || !bus.req[sel_q]) begin
          state_d = GAP;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q - BURST_W'(1);
        end
      end
      default: begin
        // last was already updated on entry to GAP, so GAP arbitrates against the just-finished channel.
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          cnt_d   = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    in_d   = (state_d == GRANT);
    busy_d = (state_d == GRANT);
    done_d = (state_d == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      in_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.in         = in_q;
  assign bus.busy       = busy_q;
  assign bus.grant_done = done_q;
endmodule

// File: tb/tb_rr_demux_sched.sv
// tb/tb_rr_demux_sched.sv - self-checking bench for rr_demux_sched with directed scenarios and a random reference model
module tb_rr_demux_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  rr_demux_sched_if #(.BURST_W(4)) bus ();

  rr_demux_sched #(.BURST_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=grant 2=gap; remaining = grant cycles still owed.
  int m_mode = 0;
  int m_last = 7;
  int m_rem  = 0;
  int m_chan = 0;

  task automatic model_step();
    bit hit;
    int c;
    if (rst) begin
      m_mode = 0; m_last = 7; m_rem = 0; m_chan = 0;
    end else if (m_mode == 1) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 || !bus.req[m_chan]) begin
        m_mode = 2;
        m_last = m_chan;
      end
    end else begin
      hit = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        c = (m_last + k) % 8;
        if (!hit && bus.req[c]) begin
          hit = 1'b1;
          m_chan = c;
        end
      end
      if (hit) begin
        m_mode = 1;
        m_rem  = (bus.burst_len == 0) ? 1 : int'(bus.burst_len);
      end else begin
        m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 8'h00; bus.burst_len = 4'd0;
    tick(); tick();
    total++;
    if ({bus.sel, bus.in, bus.busy, bus.grant_done} !== 6'b000_000) begin
      bad++; $display("FAIL reset_outputs got sel=%0d in=%0b busy=%0b done=%0b want all 0", bus.sel, bus.in, bus.busy, bus.grant_done);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({bus.in, bus.busy, bus.grant_done} !== 3'b000) begin
      bad++; $display("FAIL reset_idle got in=%0b busy=%0b done=%0b want 0", bus.in, bus.busy, bus.grant_done);
    end
  endtask

  task automatic test_single();
    bus.req = 8'h20; bus.burst_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.in !== 1'b1 || bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL single_grant cyc%0d got sel=%0d in=%0b busy=%0b want sel=5 in=1 busy=1", i, bus.sel, bus.in, bus.busy);
      end
    end
    bus.req = 8'h00;
    tick();
    total++;
    if (bus.in !== 1'b0 || bus.grant_done !== 1'b1 || bus.sel !== 3'd5 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_gap got sel=%0d in=%0b busy=%0b done=%0b want sel=5 in=0 busy=0 done=1", bus.sel, bus.in, bus.busy, bus.grant_done);
    end
    tick();
    total++;
    if (bus.in !== 1'b0 || bus.grant_done !== 1'b0 || bus.sel !== 3'd5) begin
      bad++; $display("FAIL single_idle got sel=%0d in=%0b done=%0b want sel=5 in=0 done=0", bus.sel, bus.in, bus.grant_done);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 8'hFF; bus.burst_len = 4'd2;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        total++;
        if (bus.in !== 1'b1 || bus.sel !== 3'(g % 8)) begin
          bad++; $display("FAIL rr_grant g%0d c%0d got sel=%0d in=%0b want sel=%0d in=1", g, c, bus.sel, bus.in, g % 8);
        end
      end
      tick();
      total++;
      if (bus.in !== 1'b0 || bus.grant_done !== 1'b1) begin
        bad++; $display("FAIL rr_gap g%0d got in=%0b done=%0b want in=0 done=1", g, bus.in, bus.grant_done);
      end
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_early_release();
    int high;
    high = 0;
    bus.req = 8'h04; bus.burst_len = 4'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.in === 1'b1 && bus.sel === 3'd2) high++;
    end
    bus.req = 8'h00;
    tick();
    total++;
    if (bus.in !== 1'b0 || bus.grant_done !== 1'b1) begin
      bad++; $display("FAIL early_release got in=%0b done=%0b want in=0 done=1", bus.in, bus.grant_done);
    end
    total++;
    if (high !== 4) begin
      bad++; $display("FAIL early_in_high got %0d cycles want 4", high);
    end
    tick();
    total++;
    if (bus.grant_done !== 1'b0 || bus.in !== 1'b0) begin
      bad++; $display("FAIL early_single_pulse got done=%0b in=%0b want 0 0", bus.grant_done, bus.in);
    end
  endtask

  task automatic test_burst_zero_wrap();
    bus.req = 8'h80; bus.burst_len = 4'd1;
    tick();
    bus.req = 8'h00;
    tick(); tick();
    bus.req = 8'h81; bus.burst_len = 4'd0;
    tick();
    total++;
    if (bus.in !== 1'b1 || bus.sel !== 3'd0) begin
      bad++; $display("FAIL wrap_ch0 got sel=%0d in=%0b want sel=0 in=1", bus.sel, bus.in);
    end
    tick();
    total++;
    if (bus.in !== 1'b0 || bus.grant_done !== 1'b1 || bus.sel !== 3'd0) begin
      bad++; $display("FAIL zero_len_gap got sel=%0d in=%0b done=%0b want sel=0 in=0 done=1", bus.sel, bus.in, bus.grant_done);
    end
    tick();
    total++;
    if (bus.in !== 1'b1 || bus.sel !== 3'd7) begin
      bad++; $display("FAIL wrap_ch7 got sel=%0d in=%0b want sel=7 in=1", bus.sel, bus.in);
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 8'h08; bus.burst_len = 4'd5;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if ({bus.sel, bus.in, bus.busy, bus.grant_done} !== 6'b000_000) begin
      bad++; $display("FAIL midrst got sel=%0d in=%0b busy=%0b done=%0b want all 0", bus.sel, bus.in, bus.busy, bus.grant_done);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.in !== 1'b1 || bus.sel !== 3'd3 || bus.grant_done !== 1'b0) begin
      bad++; $display("FAIL midrst_regrant got sel=%0d in=%0b done=%0b want sel=3 in=1 done=0", bus.sel, bus.in, bus.grant_done);
    end
    bus.req = 8'h00;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0] demux;
    logic [5:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.burst_len = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      tick();
      want = {3'(m_chan), m_mode == 1, m_mode == 1, m_mode == 2};
      total++;
      if ({bus.sel, bus.in, bus.busy, bus.grant_done} !== want) begin
        bad++; $display("FAIL rand_model n=%0d got sel=%0d in=%0b busy=%0b done=%0b want sel=%0d in=%0b busy=%0b done=%0b",
                        n, bus.sel, bus.in, bus.busy, bus.grant_done, want[5:3], want[2], want[1], want[0]);
      end
      demux = bus.in ? (8'h01 << bus.sel) : 8'h00;
      total++;
      if ($countones(demux) > 1 || (!bus.busy && bus.in)) begin
        bad++; $display("FAIL rand_onehot n=%0d got demux=%02h busy=%0b want onehot and in=0 when idle", n, demux, bus.busy);
      end
    end
    rst = 1'b0; bus.req = 8'h00;
    tick();
  endtask

  initial begin
    bus.req = 8'h00;
    bus.burst_len = 4'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_burst_zero_wrap();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_demux_sched.md
# rr_demux_sched

Round-robin channel scheduler sitting directly upstream of the 1-to-8 demultiplexer. It watches eight request lines and picks one requester at a time. It drives the demux select with the winning channel and drives the demux data input high for a programmable burst, so exactly one demux output is active. All outputs are registered, and the demux stays purely combinational behind it.

## Interface
Parameters:
- BURST_W, 4: width of the burst-length input and internal burst counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  per-channel request, level-sensitive; bit n requests demux output n.
- burst_len  input  BURST_W  grant length in cycles; sampled when a grant starts; 0 treated as 1.
- sel  output  3  channel index driven to the demux select.
- in  output  1  demux data input; high only while a grant is active.
- busy  output  1  high in GRANT state.
- grant_done  output  1  one-cycle pulse in the cycle after a grant ends.

## Operation
- Reset values, held while rst=1 and after the first edge with rst=1:
  - sel=0, in=0, busy=0, grant_done=0.
  - state=IDLE, last=7 (channel 0 has first priority), counter=0.
- States: IDLE, GRANT, GAP.
- Arbitration, performed in IDLE and GAP:
  - Search req from channel last+1 upward, wrapping 7→0.
  - The first set bit wins.
  - If no bit is set, go to or stay in IDLE.
- Winner found:
  - Next edge enters GRANT, with sel=winner, in=1, busy=1.
  - counter=max(burst_len,1).
  - last is not yet updated.
- GRANT, each edge:
  - If counter==1 or req[sel]==0, go to GAP. This gives an early release when the requester drops.
  - Otherwise counter decrements.
- GAP, exactly one cycle:
  - in=0, busy=0, grant_done=1.
  - sel holds the granted channel.
  - last is updated to that channel.
  - Arbitration runs using the updated last, so the next edge goes to GRANT (new winner) or to IDLE.
- In IDLE, sel holds its previous value and in=0.
- One-hot guarantee: at most one demux output is high in any cycle. The demux output is all-zero in IDLE and GAP.
- Fairness: a channel that just finished has lowest priority at the next arbitration. If all eight request continuously, the grant order is 0,1,…,7,0.
- Simultaneous events:
  - A req change in the same cycle as arbitration uses the sampled value at that edge.
  - burst_len changes mid-grant are ignored.
- Reset mid-grant:
  - Next edge goes to IDLE with in=0.
  - No grant_done pulse is produced.
  - last returns to 7.
- Counter width: BURST_W bits. The maximum burst is 2^BURST_W−1 cycles.

## Timing
- Request to grant: req[n] set before edge k (state IDLE) gives in=1, sel=n from edge k, i.e. one-cycle latency.
- A burst of L cycles with req held:
  - in is high for exactly L cycles.
  - The next cycle is GAP, with in=0 and grant_done=1.
- Back-to-back grant period: L+1 cycles, because GAP arbitrates directly.
- Early release:
  - req[sel] low before edge j during GRANT makes in=0 from edge j.
  - grant_done is asserted from edge j.
- sel changes only on the edge entering GRANT, never while in=1.

## Test plan
- Reset then single request: rst=1 for 2 cycles, then req=8'h20 and burst_len=3 → one cycle later sel=5 and in=1 for 3 cycles, then grant_done=1 for 1 cycle, then IDLE with in=0.
- Round-robin fairness: req=8'hFF held, burst_len=2 → grant sequence 0,1,2,…,7,0. Each grant has in high for 2 cycles, then 1 GAP cycle (period 3).
- Early release: req=8'h04, burst_len=10; drop req[2] after 4 grant cycles → in low on the following edge, grant_done pulses once, total in-high is 4 cycles.
- burst_len=0 plus wrap-around: last grant was channel 7, req=8'h81, burst_len=0 → channel 0 is granted for exactly 1 cycle, then channel 7 next.
- Reset mid-burst: assert rst during cycle 2 of a 5-cycle grant on channel 3 → next edge gives in=0, busy=0, sel=0, no grant_done; with req=8'h08 still held after rst drops, channel 3 is regranted one cycle later.
- One-hot check: random req and burst_len for 10k cycles with a demux model → at most one demux output high every cycle, and in=0 whenever busy=0.
